// File: rtl/header_lock_tracker_if.sv
// Gearbox-slice / lock-status bundle for header_lock_tracker.
// err_cnt_o exists only when HLT_ERR_CNT_EN is defined.
interface header_lock_tracker_if #(
  parameter int BLOCK_W = 66
);
  localparam int OFF_W = $clog2(BLOCK_W + 1);

  logic [BLOCK_W:0]  win_i;
  logic              win_dv_i;
  logic [OFF_W-1:0]  block_offset_o;
  logic              locked_o;
  logic              lock_lost_o;
  logic              hdr_valid_o;
`ifdef HLT_ERR_CNT_EN
  logic [15:0]       err_cnt_o;

  modport master (
    output win_i, win_dv_i,
    input  block_offset_o, locked_o, lock_lost_o,
    input  hdr_valid_o, err_cnt_o
  );
  modport slave (
    input  win_i, win_dv_i,
    output block_offset_o, locked_o, lock_lost_o,
    output hdr_valid_o, err_cnt_o
  );
`else
  modport master (
    output win_i, win_dv_i,
    input  block_offset_o, locked_o, lock_lost_o,
    input  hdr_valid_o
  );
  modport slave (
    input  win_i, win_dv_i,
    output block_offset_o, locked_o, lock_lost_o,
    output hdr_valid_o
  );
`endif
endinterface

// File: rtl/header_lock_tracker.sv
// Parallel sync-header seekers feeding a SEARCH/LOCKED block-lock FSM.
// Optional bad-header counter (err_cnt_o) enabled by HLT_ERR_CNT_EN.
module header_lock_tracker #(
  parameter int BLOCK_W        = 66,
  parameter int N_SEEKERS      = 6,
  parameter int CNT_W          = 6,
  parameter int LOCK_THRESH    = 32,
  parameter int WINDOW         = 64,
  parameter int UNLOCK_BAD_MAX = 16
) (
  input logic clk_i,
  input logic rst_i,
  header_lock_tracker_if.slave bus
);
  localparam int OFF_W = $clog2(BLOCK_W + 1);
  localparam int K     = BLOCK_W / N_SEEKERS;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int NG    = (N_SEEKERS + 3) / 4;
  localparam int NP    = NG * 4;
  localparam int WC_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int BAD_W = $clog2(UNLOCK_BAD_MAX + 1);

  typedef enum logic {S_SEARCH, S_LOCKED} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt [N_SEEKERS];
  logic [IDX_W-1:0] r_idx [N_SEEKERS];
  logic [CNT_W-1:0] r_ga_cnt [NG];
  logic [OFF_W-1:0] r_ga_off [NG];
  logic [CNT_W-1:0] r_cand_cnt;
  logic [OFF_W-1:0] r_cand_off;
  logic [OFF_W-1:0] r_lock_off;
  logic [BAD_W-1:0] r_bad;
  logic [WC_W-1:0]  r_wc;
  logic [OFF_W-1:0] r_off;
  logic             r_locked;
  logic             r_lost;
  logic             r_hv;

  logic [OFF_W-1:0] w_off  [N_SEEKERS];
  logic             w_good [N_SEEKERS];
  logic [CNT_W-1:0] w_pcnt [NP];
  logic [OFF_W-1:0] w_poff [NP];
  logic [CNT_W-1:0] w_ga_cnt [NG];
  logic [OFF_W-1:0] w_ga_off [NG];
  logic [CNT_W-1:0] w_cb_cnt;
  logic [OFF_W-1:0] w_cb_off;
  logic             w_lgood;
  logic [BAD_W-1:0] w_bad_nxt;

  // Offset = header position - 1, so the header is win_i[off +: 2].
  always_comb begin
    for (int s = 0; s < N_SEEKERS; s++) begin
      w_off[s]  = OFF_W'(s)
                + OFF_W'(r_idx[s]) * OFF_W'(N_SEEKERS);
      w_good[s] = ^bus.win_i[w_off[s] +: 2];
    end
  end

  // Padding slots carry cnt 0, which never wins a strict compare.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      w_pcnt[i] = '0;
      w_poff[i] = '0;
    end
    for (int s = 0; s < N_SEEKERS; s++) begin
      w_pcnt[s] = r_cnt[s];
      w_poff[s] = w_off[s];
    end
    for (int g = 0; g < NG; g++) begin
      w_ga_cnt[g] = w_pcnt[4*g];
      w_ga_off[g] = w_poff[4*g];
      for (int j = 1; j < 4; j++) begin
        if (w_pcnt[4*g+j] > w_ga_cnt[g]) begin
          w_ga_cnt[g] = w_pcnt[4*g+j];
          w_ga_off[g] = w_poff[4*g+j];
        end
      end
    end
  end

  always_comb begin
    w_cb_cnt = r_ga_cnt[0];
    w_cb_off = r_ga_off[0];
    for (int g = 1; g < NG; g++) begin
      if (r_ga_cnt[g] > w_cb_cnt) begin
        w_cb_cnt = r_ga_cnt[g];
        w_cb_off = r_ga_off[g];
      end
    end
  end

  assign w_lgood   = ^bus.win_i[r_lock_off +: 2];
  assign w_bad_nxt = r_bad + (w_lgood ? BAD_W'(0) : BAD_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_SEARCH;
      for (int s = 0; s < N_SEEKERS; s++) begin
        r_cnt[s] <= '0;
        r_idx[s] <= '0;
      end
      for (int g = 0; g < NG; g++) begin
        r_ga_cnt[g] <= '0;
        r_ga_off[g] <= '0;
      end
      r_cand_cnt <= '0;
      r_cand_off <= '0;
      r_lock_off <= '0;
      r_bad      <= '0;
      r_wc       <= '0;
      r_off      <= '0;
      r_locked   <= 1'b0;
      r_lost     <= 1'b0;
      r_hv       <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      for (int g = 0; g < NG; g++) begin
        r_ga_cnt[g] <= w_ga_cnt[g];
        r_ga_off[g] <= w_ga_off[g];
      end
      r_cand_cnt <= w_cb_cnt;
      r_cand_off <= w_cb_off;
      if (bus.win_dv_i) begin
        unique case (r_state)
          S_SEARCH: begin
            r_off <= r_cand_off;
            for (int s = 0; s < N_SEEKERS; s++) begin
              if (w_good[s]) begin
                if (r_cnt[s] != {CNT_W{1'b1}})
                  r_cnt[s] <= r_cnt[s] + 1'b1;
              end else begin
                r_cnt[s] <= '0;
                if (r_idx[s] == IDX_W'(K - 1))
                  r_idx[s] <= '0;
                else
                  r_idx[s] <= r_idx[s] + 1'b1;
              end
            end
            if (r_cand_cnt >= CNT_W'(LOCK_THRESH)) begin
              r_state    <= S_LOCKED;
              r_locked   <= 1'b1;
              r_lock_off <= r_cand_off;
              r_bad      <= '0;
              r_wc       <= '0;
            end
          end
          S_LOCKED: begin
            r_hv <= w_lgood;
            // Unlock wins over a coincident window rollover.
            if (w_bad_nxt == BAD_W'(UNLOCK_BAD_MAX)) begin
              r_state  <= S_SEARCH;
              r_locked <= 1'b0;
              r_lost   <= 1'b1;
              r_hv     <= 1'b0;
              for (int s = 0; s < N_SEEKERS; s++) begin
                r_cnt[s] <= '0;
                r_idx[s] <= '0;
              end
            end else if (r_wc == WC_W'(WINDOW - 1)) begin
              r_wc  <= '0;
              r_bad <= '0;
            end else begin
              r_wc  <= r_wc + 1'b1;
              r_bad <= w_bad_nxt;
            end
          end
        endcase
      end
    end
  end

  assign bus.block_offset_o = r_off;
  assign bus.locked_o       = r_locked;
  assign bus.lock_lost_o    = r_lost;
  assign bus.hdr_valid_o    = r_hv;

`ifdef HLT_ERR_CNT_EN
  logic [15:0] r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_err <= '0;
    else if (bus.win_dv_i && r_state == S_LOCKED
             && !w_lgood && r_err != 16'hFFFF)
      r_err <= r_err + 1'b1;
  end

  assign bus.err_cnt_o = r_err;
`endif

endmodule

// File: tb/tb_header_lock_tracker.sv
// Self-checking bench for header_lock_tracker: vector table, directed
// lock/unlock sequences and random traffic against a behavioural model.
module tb_header_lock_tracker;
  localparam int BW   = 66;
  localparam int NS   = 6;
  localparam int K    = BW / NS;
  localparam int CMAX = 63;
  localparam int THR  = 32;
  localparam int WIN  = 64;
  localparam int UBM  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  header_lock_tracker_if #(.BLOCK_W(BW)) bus ();

  header_lock_tracker #(
    .BLOCK_W(BW), .N_SEEKERS(NS), .CNT_W(6),
    .LOCK_THRESH(THR), .WINDOW(WIN), .UNLOCK_BAD_MAX(UBM)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int m_cnt [NS];
  int m_idx [NS];
  bit m_lk, m_hv, m_lost;
  int m_pos, m_bad, m_wc, m_off, m_err;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic bit good(input logic [BW:0] w, input int p);
    return w[p] != w[p-1];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_cnt[s] = 0;
      m_idx[s] = 0;
    end
    m_lk = 0; m_hv = 0; m_lost = 0;
    m_pos = 0; m_bad = 0; m_wc = 0; m_off = 0; m_err = 0;
  endtask

  // Spec-level model: best seeker = highest count, lowest index on ties.
  task automatic model_step(input logic [BW:0] w);
    int b;
    int p;
    bit g;
    m_lost = 0;
    if (!m_lk) begin
      b = 0;
      for (int s = 1; s < NS; s++)
        if (m_cnt[s] > m_cnt[b]) b = s;
      m_off = b + m_idx[b] * NS;
      if (m_cnt[b] >= THR) begin
        m_lk = 1; m_pos = m_off + 1; m_bad = 0; m_wc = 0;
      end
      for (int s = 0; s < NS; s++) begin
        p = s + 1 + m_idx[s] * NS;
        if (good(w, p)) begin
          if (m_cnt[s] < CMAX) m_cnt[s]++;
        end else begin
          m_cnt[s] = 0;
          m_idx[s] = (m_idx[s] + 1) % K;
        end
      end
    end else begin
      g = good(w, m_pos);
      m_hv = g;
      if (!g) begin
        m_bad++;
        if (m_err < 65535) m_err++;
      end
      if (m_bad >= UBM) begin
        m_lk = 0; m_lost = 1; m_hv = 0;
        for (int s = 0; s < NS; s++) begin
          m_cnt[s] = 0;
          m_idx[s] = 0;
        end
      end else if (m_wc == WIN - 1) begin
        m_wc = 0; m_bad = 0;
      end else begin
        m_wc++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dv(input logic [BW:0] w);
    bus.win_i    = w;
    bus.win_dv_i = 1'b1;
    @(posedge clk);
    #1;
    bus.win_dv_i = 1'b0;
    model_step(w);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    bus.win_dv_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cmp_model(input string nm);
    chk({nm, "_off"},  int'(bus.block_offset_o), m_off);
    chk({nm, "_lock"}, int'(bus.locked_o),       int'(m_lk));
    chk({nm, "_lost"}, int'(bus.lock_lost_o),    int'(m_lost));
    chk({nm, "_hv"},   int'(bus.hdr_valid_o),    int'(m_hv));
`ifdef HLT_ERR_CNT_EN
    chk({nm, "_err"},  int'(bus.err_cnt_o),      m_err);
`endif
  endtask

  function automatic logic [BW:0] rnd_win();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[BW:0];
  endfunction

  // Header at position 13; positions 1 and 7 forced bad so seeker 0
  // walks straight onto it.
  function automatic logic [BW:0] mk(input bit badh);
    logic [BW:0] w;
    bit x;
    w = rnd_win();
    x = w[40];
    w[1:0]   = 2'b00;
    w[7:6]   = 2'b11;
    w[13:12] = badh ? {x, x} : {x, ~x};
    return w;
  endfunction

  task automatic relock(input string nm);
    int n;
    n = 0;
    while (!bus.locked_o && n <= 60) begin
      dv(mk(1'b0));
      idle(7);
      n++;
    end
    chk({nm, "_dvs"}, n, 35);
    chk({nm, "_off"}, int'(bus.block_offset_o), 12);
  endtask

  typedef struct {
    logic [BW:0] w;
    int          off;
    bit          lk;
    bit          hv;
  } vec_t;

  vec_t        tv [6];
  logic [BW:0] w;
  int          rp, pb, lost_seen;
  bit          bh, x;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.win_i = '0;
    bus.win_dv_i = 1'b0;
    idle(3);
    rst = 1'b0;
    model_reset();
    cmp_model("por");

    for (int r = 0; r < 4; r++) begin
      rp = $urandom_range(1, BW);
      pb = $urandom_range(5, 35);
      for (int i = 0; i < 150; i++) begin
        w  = rnd_win();
        x  = w[33];
        bh = (i >= 50) && ($urandom_range(0, 99) < pb);
        w[rp -: 2] = bh ? {x, x} : {x, ~x};
        dv(w);
        cmp_model("rnd");
        idle($urandom_range(2, 5));
      end
    end

    pulse_rst();
    chk("rst_off",  int'(bus.block_offset_o), 0);
    chk("rst_lock", int'(bus.locked_o), 0);
    chk("rst_lost", int'(bus.lock_lost_o), 0);
    chk("rst_hv",   int'(bus.hdr_valid_o), 0);
`ifdef HLT_ERR_CNT_EN
    chk("rst_err",  int'(bus.err_cnt_o), 0);
`endif

    for (int i = 0; i < 6; i++) begin
      tv[i].w  = '0;
      tv[i].lk = 1'b0;
      tv[i].hv = 1'b0;
    end
    tv[0].off = 0;
    tv[1].off = 6;
    tv[2].w[13:12] = 2'b01;
    tv[2].off = 12;
    tv[3].off = 12;
    tv[4].w[26:25] = 2'b10;
    tv[4].off = 18;
    tv[5].off = 25;
    for (int i = 0; i < 6; i++) begin
      dv(tv[i].w);
      chk($sformatf("tv%0d_off", i), int'(bus.block_offset_o), tv[i].off);
      chk($sformatf("tv%0d_lock", i), int'(bus.locked_o), int'(tv[i].lk));
      chk($sformatf("tv%0d_hv", i), int'(bus.hdr_valid_o), int'(tv[i].hv));
      idle(2);
    end

    pulse_rst();
    relock("lock1");
    for (int i = 0; i < WIN; i++) begin
      dv(mk(i >= 49));
      if (i == 0) chk("lock1_hv", int'(bus.hdr_valid_o), 1);
      if (i == WIN - 1)
        chk("bad15_lock", int'(bus.locked_o), 1);
      idle(7);
    end
    for (int i = 0; i < UBM; i++) begin
      dv(mk(1'b1));
      if (i == UBM - 2)
        chk("bad15b_lock", int'(bus.locked_o), 1);
      if (i == UBM - 1) begin
        chk("unlock_lost", int'(bus.lock_lost_o), 1);
        chk("unlock_lock", int'(bus.locked_o), 0);
        idle(1);
        chk("unlock_lost_1cyc", int'(bus.lock_lost_o), 0);
        chk("unlock_hv", int'(bus.hdr_valid_o), 0);
        chk("unlock_lock2", int'(bus.locked_o), 0);
      end
      idle(7);
    end

    relock("lock2");
    lost_seen = 0;
    for (int i = 0; i < 2 * WIN; i++) begin
      dv(mk((i >= 50 && i < 60) || (i >= WIN && i < WIN + 10)));
      lost_seen += int'(bus.lock_lost_o);
      idle(7);
    end
    chk("roll_lock", int'(bus.locked_o), 1);
    chk("roll_lost", lost_seen, 0);

    pulse_rst();
    chk("mid_rst_lock", int'(bus.locked_o), 0);
    chk("mid_rst_off",  int'(bus.block_offset_o), 0);
    chk("mid_rst_hv",   int'(bus.hdr_valid_o), 0);
    relock("lock3");

`ifdef HLT_ERR_CNT_EN
    for (int i = 0; i < 20; i++) begin
      dv(mk(1'b1));
      if (i == UBM - 1) begin
        chk("err_unlock_lost", int'(bus.lock_lost_o), 1);
        chk("err_at_unlock", int'(bus.err_cnt_o), 16);
      end
      idle(7);
    end
    chk("err_search", int'(bus.err_cnt_o), 16);
    chk("err_search_lock", int'(bus.locked_o), 0);
    pulse_rst();
    chk("err_rst", int'(bus.err_cnt_o), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/header_lock_tracker.md
Name: header_lock_tracker

Overview:
- Parametrised successor to the 66b header seeker.
- Finds the 2-bit sync header position in a (BLOCK_W+1)-bit buffer slice using N_SEEKERS parallel scanning seekers.
- Adds a SEARCH/LOCKED state machine: it declares lock after LOCK_THRESH consecutive good headers and drops lock when UNLOCK_BAD_MAX bad headers fall inside a WINDOW-block window.
- Sits between the gearbox buffer and the block aligner.

Parameters:
- BLOCK_W, 66, block length in bits; header positions are 1..BLOCK_W.
- N_SEEKERS, 6, number of parallel seekers. Must divide BLOCK_W.
- CNT_W, 6, width of each seeker's consecutive-good counter. The counter saturates.
- LOCK_THRESH, 32, consecutive good headers needed to lock. Must be ≤ 2^CNT_W-1.
- WINDOW, 64, number of valid blocks per bad-header monitoring window while LOCKED.
- UNLOCK_BAD_MAX, 16, bad headers within one window that force unlock.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- win_i  in  BLOCK_W+1  buffer slice that contains one header
- win_dv_i  in  1  win_i valid. Asserted for one cycle, with at least 2 idle cycles between assertions.
- block_offset_o  out  $clog2(BLOCK_W+1)  header position minus 1
- locked_o  out  1  block lock achieved
- lock_lost_o  out  1  one-cycle pulse on LOCKED->SEARCH
- hdr_valid_o  out  1  while LOCKED: header at the locked position was valid on the last win_dv_i
- err_cnt_o  out  16  present only with HLT_ERR_CNT_EN

Behaviour:
- Header definition:
  - Header at position p is win_i[p:p-1].
  - A header is good when it equals 2'b01 or 2'b10; 00 and 11 are bad.
- Seeker positions: seeker s (0..N_SEEKERS-1) covers p = s+1+k*N_SEEKERS for k = 0..BLOCK_W/N_SEEKERS-1. Its index idx_s starts at k=0.
- Seeker update (SEARCH only, on win_dv_i), registered at the end of the dv cycle:
  - Good header: cnt_s increments, saturating at 2^CNT_W-1; idx_s holds.
  - Bad header: cnt_s clears to 0; idx_s advances and wraps from the last k to 0.
- Winner tree, 2 register stages running every cycle regardless of dv:
  - Stage A: per group of up to 4 seekers, selects max cnt and its position-1.
  - Stage B: reduces the group results to cand_cnt / cand_off.
  - Compare is strictly greater-than, so ties go to the lowest seeker index.
  - The 2-idle-cycle dv rule guarantees the candidate is settled before the next dv.
- SEARCH state, on win_dv_i:
  - block_offset_o <= cand_off.
  - If cand_cnt >= LOCK_THRESH: go LOCKED. locked_o <= 1, lock_pos <= cand_off+1, bad_cnt = 0, win_cnt = 0.
- LOCKED state:
  - Seekers and block_offset_o are frozen.
  - On each win_dv_i:
    - hdr_valid_o <= good(win_i[lock_pos:lock_pos-1]).
    - If the header is bad, bad_cnt increments.
  - win_cnt increments on every dv. On the dv where win_cnt == WINDOW-1, both win_cnt and bad_cnt clear.
  - If the incremented bad_cnt reaches UNLOCK_BAD_MAX: go SEARCH. locked_o <= 0; lock_lost_o pulses for 1 cycle; all cnt_s and idx_s clear; hdr_valid_o <= 0.
  - If the unlock condition coincides with the window rollover, unlock takes priority.
- Reset (any time, including mid-lock):
  - State returns to SEARCH.
  - All counters, indices and pipeline registers clear to 0.
  - Outputs block_offset_o=0, locked_o=0, lock_lost_o=0, hdr_valid_o=0, err_cnt_o=0.
- When win_dv_i is low, all state holds except the free-running winner tree.

Optional Feature:
- HLT_ERR_CNT_EN defined:
  - err_cnt_o is a 16-bit counter of bad headers seen while LOCKED.
  - It saturates at 16'hFFFF.
  - It clears only on rst_i.
  - It is not cleared by unlock.
- HLT_ERR_CNT_EN undefined: the port and the counter are absent.

Test Plan:
- Reset after random traffic -> next cycle all outputs 0 and state SEARCH. Then the first dv with all-zero win_i -> block_offset_o=0, locked_o=0.
- LFSR-random payload with header 2'b01/2'b10 fixed at position 13 (win_i[13:12]), dv every 8 cycles -> locked_o=1 within 32+BLOCK_W/N_SEEKERS dv, block_offset_o=12, hdr_valid_o=1.
- Locked at offset 12, then 15 bad headers within one 64-dv window -> locked_o stays 1. Next window: 16 bad headers -> on the 16th bad dv, lock_lost_o pulses exactly 1 cycle, locked_o=0, and hdr_valid_o=0 on the next cycle.
- Locked: 10 bad headers in dv 50..59 of one window and 10 bad headers in the next window -> no unlock (rollover cleared bad_cnt).
- Locked at offset 12, rst_i asserted for one cycle -> locked_o=0, block_offset_o=0. Relock on the same stream reaches offset 12 again.
- HLT_ERR_CNT_EN defined: 20 bad headers while locked -> err_cnt_o=16 at unlock; it stays 16 through SEARCH and returns to 0 only on rst_i.
